dmem_arbiter: RTL and testbench

- Shares the single-port 32-bit byte-enabled data memory between two requesters: port A (core load/store unit) and port B (debug/DMA).
- Arbitrates round-robin and steers address, data, byte enables and write enable to the memory.
- Returns read data to the granted port when the memory's 1-cycle registered read completes.
- Supports a bus lock for atomic read-modify-write, with a lock timeout that prevents starvation.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enabled data memory between
// the core LSU (port A) and debug/DMA (port B), with a timed bus lock.
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W+1:0] a_addr,
    input  logic [ADDR_W+1:0] b_addr,
    input  logic [3:0]        a_be,
    input  logic [3:0]        b_be,
    input  logic [31:0]       a_wdata,
    input  logic [31:0]       b_wdata,
    input  logic              a_lock,
    input  logic              b_lock,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [31:0]       a_rdata,
    output logic [31:0]       b_rdata,
    output logic              a_lock_err,
    output logic              b_lock_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteena,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {LK_FREE, LK_HELD} lock_state_t;
    typedef enum logic {OWN_A, OWN_B}     port_t;

    lock_state_t      r_lock_state, w_lock_state_nxt;
    port_t            r_lock_owner, w_lock_owner_nxt;
    logic [CNT_W-1:0] r_lock_cnt,   w_lock_cnt_nxt;
    port_t            r_last_gnt;
    logic             r_a_rvalid, r_b_rvalid;

    logic  w_a_gnt, w_b_gnt, w_any_gnt;
    logic  w_sel_we, w_sel_lock, w_expire;
    port_t w_gnt_port;

    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (r_lock_state == LK_HELD) begin
            w_a_gnt = a_req && (r_lock_owner == OWN_A);
            w_b_gnt = b_req && (r_lock_owner == OWN_B);
        end else if (a_req && b_req) begin
            w_a_gnt = (r_last_gnt == OWN_B);
            w_b_gnt = (r_last_gnt == OWN_A);
        end else begin
            w_a_gnt = a_req;
            w_b_gnt = b_req;
        end
    end

    assign w_any_gnt  = w_a_gnt | w_b_gnt;
    assign w_gnt_port = w_b_gnt ? OWN_B : OWN_A;

    // Port A's fields are presented whenever B is not granted, including idle.
    assign w_sel_we    = w_b_gnt ? b_we   : a_we;
    assign w_sel_lock  = w_b_gnt ? b_lock : a_lock;
    assign mem_address = w_b_gnt ? b_addr[ADDR_W+1:2] : a_addr[ADDR_W+1:2];
    assign mem_data    = w_b_gnt ? b_wdata : a_wdata;
    assign mem_byteena = w_sel_we ? (w_b_gnt ? b_be : a_be) : 4'b1111;
    assign mem_wren    = reset_n & w_any_gnt & w_sel_we;

    assign w_expire = (r_lock_state == LK_HELD) && (r_lock_cnt == CNT_W'(LOCK_MAX - 1));

    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_lock_owner_nxt = r_lock_owner;
        w_lock_cnt_nxt   = r_lock_cnt;
        if (r_lock_state == LK_HELD) begin
            if (r_lock_cnt != '1)
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            if (w_expire || (w_any_gnt && !w_sel_lock))
                w_lock_state_nxt = LK_FREE;
        end
        // A locking request granted in the expiry cycle does not re-take the lock.
        if (w_any_gnt && w_sel_lock && !w_expire) begin
            w_lock_state_nxt = LK_HELD;
            w_lock_owner_nxt = w_gnt_port;
            w_lock_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_state <= LK_FREE;
            r_lock_owner <= OWN_A;
            r_lock_cnt   <= '0;
            r_last_gnt   <= OWN_B;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            if (w_any_gnt)
                r_last_gnt <= w_gnt_port;
            r_a_rvalid <= w_a_gnt && !a_we;
            r_b_rvalid <= w_b_gnt && !b_we;
        end
    end

    assign a_gnt      = w_a_gnt;
    assign b_gnt      = w_b_gnt;
    assign a_rvalid   = r_a_rvalid;
    assign b_rvalid   = r_b_rvalid;
    assign a_rdata    = mem_q;
    assign b_rdata    = mem_q;
    assign a_lock_err = w_expire && (r_lock_owner == OWN_A);
    assign b_lock_err = w_expire && (r_lock_owner == OWN_B);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration, memory steering, read return,
// lock hold/release/timeout and reset behaviour.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 15;
    localparam int LOCK_MAX = 16;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              a_req, b_req, a_we, b_we, a_lock, b_lock;
    logic [ADDR_W+1:0] a_addr, b_addr;
    logic [3:0]        a_be, b_be;
    logic [31:0]       a_wdata, b_wdata;
    logic              a_gnt, b_gnt, a_rvalid, b_rvalid, a_lock_err, b_lock_err;
    logic [31:0]       a_rdata, b_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic [31:0]       mem_q;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_a, prev_b;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_be(a_be), .b_be(b_be),
        .a_wdata(a_wdata), .b_wdata(b_wdata), .a_lock(a_lock), .b_lock(b_lock),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_lock_err(a_lock_err), .b_lock_err(b_lock_err),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
        a_addr = '0; b_addr = '0; a_be = '0; b_be = '0; a_wdata = '0; b_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle();
        next_cycle();
        next_cycle();
        reset_n = 1;
    endtask

    initial begin
        reset_n = 0;
        idle();
        mem_q = '0;
        a_req = 1; a_we = 1; a_be = 4'hF;
        #2;
        check_eq("rst_wren", mem_wren, 0);
        check_eq("rst_a_rvalid", a_rvalid, 0);
        check_eq("rst_b_rvalid", b_rvalid, 0);
        check_eq("rst_lock_err", {a_lock_err, b_lock_err}, 0);
        next_cycle();
        next_cycle();
        reset_n = 1;
        idle();

        // A read of byte address 0x0010 alone
        next_cycle();
        a_req = 1; a_addr = 17'h0010;
        #1;
        check_eq("rd_a_gnt", a_gnt, 1);
        check_eq("rd_b_gnt", b_gnt, 0);
        check_eq("rd_addr", mem_address, 32'h4);
        check_eq("rd_wren", mem_wren, 0);
        check_eq("rd_be", mem_byteena, 4'hF);
        next_cycle();
        idle(); mem_q = 32'h12345678;
        #1;
        check_eq("rd_a_rvalid", a_rvalid, 1);
        check_eq("rd_a_rdata", a_rdata, 32'h12345678);
        check_eq("rd_b_rvalid", b_rvalid, 0);
        next_cycle();
        #1;
        check_eq("rd_a_rvalid_end", a_rvalid, 0);

        // Continuous contention: A write / B read alternate starting with A
        do_reset();
        a_req = 1; a_we = 1; a_addr = 17'h0020; a_be = 4'hF; a_wdata = 32'h11111111;
        b_req = 1; b_we = 0; b_addr = 17'h0040;
        prev_b = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            #1;
            exp_a = (i % 2 == 0);
            check_eq("rr_a_gnt", a_gnt, exp_a);
            check_eq("rr_b_gnt", b_gnt, !exp_a);
            check_eq("rr_wren", mem_wren, exp_a);
            check_eq("rr_addr", mem_address, exp_a ? 32'h8 : 32'h10);
            check_eq("rr_b_rvalid", b_rvalid, prev_b);
            prev_b = !exp_a;
        end
        next_cycle();
        idle();
        #1;
        check_eq("rr_b_rvalid_last", b_rvalid, 1);

        // Byte-enabled write followed by a read
        next_cycle();
        a_req = 1; a_we = 1; a_addr = 17'h0008; a_be = 4'b0100; a_wdata = 32'hAABBCCDD;
        #1;
        check_eq("wr_gnt", a_gnt, 1);
        check_eq("wr_be", mem_byteena, 4'b0100);
        check_eq("wr_data", mem_data, 32'hAABBCCDD);
        check_eq("wr_wren", mem_wren, 1);
        check_eq("wr_addr", mem_address, 32'h2);
        next_cycle();
        a_we = 0;
        #1;
        check_eq("wr_rd_wren", mem_wren, 0);
        check_eq("wr_rd_be", mem_byteena, 4'hF);
        check_eq("wr_rd_gnt", a_gnt, 1);
        check_eq("wr_no_rvalid", a_rvalid, 0);
        next_cycle();
        idle(); a_addr = 17'h01FC;
        #1;
        check_eq("idle_wren", mem_wren, 0);
        check_eq("idle_gnt", {a_gnt, b_gnt}, 0);
        check_eq("idle_addr", mem_address, 32'h7F);
        check_eq("idle_a_rvalid", a_rvalid, 1);

        // A locks, B waits, A's unlocked write releases
        do_reset();
        a_req = 1; a_lock = 1; a_addr = 17'h0030;
        b_req = 1; b_addr = 17'h0050;
        #1;
        check_eq("lk_a_gnt0", a_gnt, 1);
        check_eq("lk_b_gnt0", b_gnt, 0);
        next_cycle();
        a_req = 0; a_lock = 0;
        #1;
        check_eq("lk_b_gnt1", b_gnt, 0);
        check_eq("lk_a_rvalid", a_rvalid, 1);
        next_cycle();
        #1;
        check_eq("lk_b_gnt2", b_gnt, 0);
        next_cycle();
        a_req = 1; a_we = 1;
        #1;
        check_eq("lk_a_gnt3", a_gnt, 1);
        check_eq("lk_b_gnt3", b_gnt, 0);
        next_cycle();
        a_req = 0; a_we = 0;
        #1;
        check_eq("lk_b_gnt4", b_gnt, 1);
        next_cycle();
        b_req = 0;
        #1;
        check_eq("lk_b_rvalid", b_rvalid, 1);

        // Lock timeout: A locks and goes idle
        do_reset();
        a_req = 1; a_lock = 1;
        #1;
        check_eq("to_a_gnt", a_gnt, 1);
        for (int k = 1; k <= 17; k++) begin
            next_cycle();
            if (k == 1) begin
                a_req = 0; a_lock = 0; b_req = 1;
            end
            #1;
            check_eq("to_a_lock_err", a_lock_err, (k == 16));
            check_eq("to_b_gnt", b_gnt, (k == 17));
            check_eq("to_b_lock_err", b_lock_err, 0);
        end
        next_cycle();
        b_req = 0;
        #1;
        check_eq("to_b_rvalid", b_rvalid, 1);

        // Reset while a B read is in flight
        next_cycle();
        b_req = 1; b_addr = 17'h0060;
        #1;
        check_eq("rf_b_gnt", b_gnt, 1);
        next_cycle();
        b_req = 0; reset_n = 0;
        #1;
        check_eq("rf_b_rvalid_rst", b_rvalid, 0);
        next_cycle();
        reset_n = 1;
        #1;
        check_eq("rf_b_rvalid_rel", b_rvalid, 0);
        next_cycle();
        a_req = 1; b_req = 1;
        #1;
        check_eq("rf_b_rvalid_after", b_rvalid, 0);
        check_eq("rf_a_first", a_gnt, 1);
        check_eq("rf_b_wait", b_gnt, 0);

        // Reset after an A grant still favours A at the next contention
        next_cycle();
        idle(); reset_n = 0;
        next_cycle();
        reset_n = 1;
        a_req = 1; b_req = 1;
        #1;
        check_eq("ra_a_first", a_gnt, 1);
        check_eq("ra_b_wait", b_gnt, 0);
        next_cycle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
